codec_tx: RTL and testbench

CODEC_TX -- requirements
Module: codec_tx

---
 rtl/codec_pkg.sv | 10 +
 rtl/float24_to_pcm24.sv | 47 ++++
 rtl/codec_tx.sv | 108 ++++++++++
 tb/tb_codec_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared constants for the floating-point to I2S transmit path.
package codec_pkg;

    localparam int               FLOAT_W  = 24;
    localparam int               PCM_W    = 24;
    localparam logic [7:0]       EXP_BIAS = 8'd127;
    localparam logic [PCM_W-1:0] PCM_MAX  = 24'h7FFFFF;
    localparam logic [PCM_W-1:0] PCM_MIN  = 24'h800000;

endpackage

// File: rtl/float24_to_pcm24.sv
// Combinational conversion of a 24-bit float (1/8/15) to 24-bit two's-complement PCM.
// Magnitudes below one PCM LSB truncate to zero; |x| >= 1.0 clips to full scale.
module float24_to_pcm24
    import codec_pkg::*;
(
    input  logic [FLOAT_W-1:0] float_in,
    output logic [PCM_W-1:0]   pcm,
    output logic               sat
);

    // Exponent at which the 16-bit mantissa sits unshifted on the PCM grid.
    localparam logic [7:0] EXP_UNITY = EXP_BIAS - 8'd8;
    // At or below this exponent every mantissa shifts out completely.
    localparam logic [7:0] EXP_FLOOR = EXP_UNITY - 8'd16;

    function automatic logic [PCM_W-1:0] saturate(input logic neg);
        return neg ? PCM_MIN : PCM_MAX;
    endfunction

    function automatic logic signed [PCM_W-1:0] apply_sign(input logic neg,
                                                           input logic [PCM_W-1:0] mag);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    logic             sign;
    logic [7:0]       exponent;
    logic [PCM_W-1:0] mant;
    logic [PCM_W-1:0] mag;

    // Align the mantissa by the exponent, detect overflow, then apply the sign.
    always_comb begin
        sign     = float_in[FLOAT_W-1];
        exponent = float_in[FLOAT_W-2 -: 8];
        mant     = {8'd0, 1'b1, float_in[14:0]};
        mag      = '0;
        sat      = 1'b0;
        if (exponent >= EXP_BIAS) begin
            sat = 1'b1;
        end else if (exponent >= EXP_UNITY) begin
            mag = mant << (exponent - EXP_UNITY);
        end else if (exponent > EXP_FLOOR) begin
            mag = mant >> (EXP_UNITY - exponent);
        end
        pcm = sat ? saturate(sign) : apply_sign(sign, mag);
    end

endmodule

// File: rtl/codec_tx.sv
// I2S transmitter: converts float samples into per-channel holding registers and
// serialises them MSB first, one bclk after each word-select change.
module codec_tx
    import codec_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] float_in,
    input  logic               float_in_ch,
    input  logic               float_in_valid,
    output logic               float_in_ready,
    output logic               codec_bclk,
    output logic               codec_lrclk,
    output logic               codec_sdata,
    output logic               sat,
    output logic               underrun
);

    localparam int               DIV_W     = $clog2(CLK_DIV);
    localparam int               CNT_W     = $clog2(2 * SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SLOT_BITS);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             started;
    logic [1:0]       full;
    logic [PCM_W-1:0] hold [2];
    logic [PCM_W-1:0] shift_reg;
    logic [PCM_W-1:0] conv_pcm;
    logic             conv_sat;
    logic             div_wrap;
    logic             fall;
    logic             load;
    logic             load_ch;
    logic             accept;

    float24_to_pcm24 u_conv (
        .float_in (float_in),
        .pcm      (conv_pcm),
        .sat      (conv_sat)
    );

    // Decode bclk falling edges and slot-start loads; the first falling edge after
    // reset opens the left slot without advancing the bit counter.
    always_comb begin
        div_wrap       = (div_cnt == DIV_LAST);
        fall           = div_wrap && codec_bclk;
        next_cnt       = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        load_ch        = started && (next_cnt == CNT_RIGHT);
        load           = fall && (!started || next_cnt == '0 || next_cnt == CNT_RIGHT);
        float_in_ready = !full[float_in_ch];
        accept         = float_in_valid && float_in_ready;
    end

    // Bit clock, frame position, holding-register occupancy and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            codec_bclk  <= 1'b0;
            bit_cnt     <= '0;
            codec_lrclk <= 1'b0;
            codec_sdata <= 1'b0;
            started     <= 1'b0;
            full        <= '0;
            sat         <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sat      <= accept && conv_sat;
            underrun <= load && !full[load_ch];
            div_cnt  <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                codec_bclk <= !codec_bclk;
            end
            if (fall) begin
                started     <= 1'b1;
                codec_sdata <= load ? 1'b0 : shift_reg[PCM_W-1];
                if (started) begin
                    bit_cnt     <= next_cnt;
                    codec_lrclk <= (next_cnt >= CNT_RIGHT);
                end
            end
            // A write landing on the load edge refills the register just drained.
            if (load) begin
                full[load_ch] <= 1'b0;
            end
            if (accept) begin
                full[float_in_ch] <= 1'b1;
            end
        end
    end

    // Sample storage and serialiser; contents only matter once flagged full or loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold[float_in_ch] <= conv_pcm;
        end
        if (fall) begin
            shift_reg <= load ? (full[load_ch] ? hold[load_ch] : '0) : (shift_reg << 1);
        end
    end

endmodule

// File: tb/tb_codec_tx.sv
// Bench for codec_tx: a driver issues float samples and queues the expected PCM
// words; a monitor rebuilds each I2S slot from the pins and scores it.
module tb_codec_tx;

    localparam int CLK_DIV   = 4;
    localparam int SLOT_BITS = 32;
    localparam int FRAME     = 2 * SLOT_BITS * 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] float_in;
    logic        float_in_ch;
    logic        float_in_valid;
    logic        float_in_ready;
    logic        codec_bclk;
    logic        codec_lrclk;
    logic        codec_sdata;
    logic        sat;
    logic        underrun;

    codec_tx #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS)) dut (
        .clk            (clk),
        .rst            (rst),
        .float_in       (float_in),
        .float_in_ch    (float_in_ch),
        .float_in_valid (float_in_valid),
        .float_in_ready (float_in_ready),
        .codec_bclk     (codec_bclk),
        .codec_lrclk    (codec_lrclk),
        .codec_sdata    (codec_sdata),
        .sat            (sat),
        .underrun       (underrun)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [23:0] pcm;
    } exp_t;

    exp_t lq[$];
    exp_t rq[$];
    bit   sat_tags[int];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   under_seen = 0;
    int   left_starts = 0;
    int   last_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_eq(input string name, input logic [31:0] act,
                                     input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Real-valued reference: value in PCM LSBs is 1.frac * 2^(e-127) * 2^23, truncated.
    function automatic void ref_conv(input logic [23:0] f, output logic [23:0] pcm,
                                     output bit s);
        int  e;
        int  mag;
        real v;
        e   = int'(f[22:15]);
        pcm = '0;
        s   = 1'b0;
        if (e == 0) return;
        v = real'(int'({1'b1, f[14:0]})) / 32768.0 * 8388608.0;
        for (int i = 127; i < e; i++) v = v * 2.0;
        for (int i = e; i < 127; i++) v = v / 2.0;
        if (v >= 8388608.0) begin
            s   = 1'b1;
            pcm = f[23] ? 24'h800000 : 24'h7FFFFF;
        end else begin
            mag = $rtoi(v);
            pcm = f[23] ? 24'(-mag) : 24'(mag);
        end
    endfunction

    function automatic logic [23:0] rand_float();
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'($urandom_range(1, 103));
            2:       e = 8'($urandom_range(104, 118));
            3, 4:    e = 8'($urandom_range(119, 126));
            default: e = 8'($urandom_range(127, 255));
        endcase
        return {1'($urandom_range(0, 1)), e, 15'($urandom)};
    endfunction

    function automatic bit model_ready(input bit ch);
        return ch ? (rq.size() == 0) : (lq.size() == 0);
    endfunction

    task automatic send(input bit ch, input logic [23:0] data);
        exp_t        item;
        logic [23:0] p;
        bit          s;
        int          waited;
        bit          done;
        waited = 0;
        done   = 1'b0;
        ref_conv(data, p, s);
        while (!done) begin
            @(negedge clk);
            float_in       = data;
            float_in_ch    = ch;
            float_in_valid = 1'b1;
            #1;
            check_eq("ready", float_in_ready, model_ready(ch));
            if (float_in_ready) begin
                item.tag = cyc + 1;
                item.pcm = p;
                if (ch) rq.push_back(item);
                else    lq.push_back(item);
                if (s) sat_tags[cyc + 1] = 1'b1;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 2 * FRAME) begin
                    check_eq("send_timeout", waited, 0);
                    done = 1'b1;
                end
            end
        end
        last_wait = waited;
        @(posedge clk);
        #1 float_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 4 * FRAME && (lq.size() + rq.size()) != 0; k++) @(negedge clk);
        check_eq("drain", lq.size() + rq.size(), 0);
    endtask

    task automatic wait_lr(input logic level);
        for (int k = 0; k < 2 * FRAME && codec_lrclk !== level; k++) @(negedge clk);
        check_eq("lrclk_wait", codec_lrclk, level);
    endtask

    task automatic wait_left_start();
        int s0;
        s0 = left_starts;
        for (int k = 0; k < 2 * FRAME && left_starts == s0; k++) begin
            @(negedge clk);
            #1;
        end
        check_eq("left_start_wait", left_starts != s0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_bclk"}, codec_bclk, 0);
        check_eq({tag, "_lrclk"}, codec_lrclk, 0);
        check_eq({tag, "_sdata"}, codec_sdata, 0);
        check_eq({tag, "_sat"}, sat, 0);
        check_eq({tag, "_underrun"}, underrun, 0);
        float_in_ch = 1'b0;
        #1 check_eq({tag, "_ready_l"}, float_in_ready, 1);
        float_in_ch = 1'b1;
        #1 check_eq({tag, "_ready_r"}, float_in_ready, 1);
    endtask

    // Monitor state
    bit          first_fall = 1'b1;
    bit          prev_bclk = 1'b0;
    bit          prev_lr = 1'b0;
    bit          slot_active = 1'b0;
    bit          slot_ch = 1'b0;
    bit          pad_bad = 1'b0;
    bit          exp_under;
    int          last_fall = -1;
    int          rel_cyc = 0;
    int          slot_bits = 0;
    logic [23:0] word = '0;
    logic [23:0] slot_exp = '0;

    always @(negedge clk) begin
        bit    start;
        bit    fall;
        exp_t  item;
        string nm;
        if (!rst) begin
            first_fall  = 1'b1;
            prev_bclk   = 1'b0;
            prev_lr     = 1'b0;
            slot_active = 1'b0;
            last_fall   = -1;
            rel_cyc     = cyc;
        end else begin
            fall      = prev_bclk && !codec_bclk;
            prev_bclk = codec_bclk;
            start     = 1'b0;
            exp_under = 1'b0;
            if (fall) begin
                if (last_fall < 0) check_eq("first_fall_delay", cyc - rel_cyc, 2 * CLK_DIV);
                else               check_eq("bclk_period", cyc - last_fall, 2 * CLK_DIV);
                last_fall = cyc;
                start = first_fall || (codec_lrclk != prev_lr);
                if (start) begin
                    if (slot_active) begin
                        nm = slot_ch ? "right_word" : "left_word";
                        check_eq("slot_len", slot_bits, SLOT_BITS);
                        check_eq(nm, word, slot_exp);
                        check_eq("pad_zero", pad_bad, 0);
                    end
                    if (first_fall) check_eq("first_slot_left", codec_lrclk, 0);
                    first_fall = 1'b0;
                    slot_ch    = codec_lrclk;
                    slot_exp   = '0;
                    exp_under  = 1'b1;
                    if (slot_ch) begin
                        if (rq.size() > 0 && rq[0].tag < cyc) begin
                            item = rq.pop_front();
                            slot_exp = item.pcm;
                            exp_under = 1'b0;
                        end
                    end else begin
                        left_starts++;
                        if (lq.size() > 0 && lq[0].tag < cyc) begin
                            item = lq.pop_front();
                            slot_exp = item.pcm;
                            exp_under = 1'b0;
                        end
                    end
                    check_eq("delay_bit", codec_sdata, 0);
                    slot_active = 1'b1;
                    slot_bits   = 1;
                    word        = '0;
                    pad_bad     = 1'b0;
                end else if (slot_active) begin
                    if (slot_bits <= 24) word = {word[22:0], codec_sdata};
                    else if (codec_sdata) pad_bad = 1'b1;
                    slot_bits++;
                end
                prev_lr = codec_lrclk;
            end
            if (start || underrun) check_eq("underrun", underrun, exp_under);
            if (underrun) under_seen++;
            if (sat_tags.exists(cyc) || sat) begin
                check_eq("sat", sat, sat_tags.exists(cyc));
                sat_tags.delete(cyc);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        float_in       = '0;
        float_in_ch    = 1'b0;
        float_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk);
        #1 rst = 1'b1;

        send(1'b0, 24'h3EC000);
        send(1'b1, 24'hBF0000);
        send(1'b0, 24'h3F8000);
        send(1'b1, 24'hFF8000);
        send(1'b0, 24'h000000);
        send(1'b1, 24'h338000);

        send(1'b0, rand_float());
        send(1'b0, rand_float());
        check_eq("b2b_stall", last_wait > 0, 1);

        wait_drain();
        wait_left_start();
        u0 = under_seen;
        wait_left_start();
        check_eq("idle_underruns", under_seen - u0, 2);

        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), rand_float());
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end

        wait_drain();
        wait_lr(1'b0);
        wait_lr(1'b1);
        send(1'b1, rand_float());
        send(1'b0, rand_float());
        repeat (20) @(negedge clk);
        #1 rst = 1'b0;
        lq.delete();
        rq.delete();
        sat_tags.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check_idle_outputs("midreset");
        end
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send(1'($urandom_range(0, 1)), rand_float());
            repeat ($urandom_range(0, 100)) @(negedge clk);
        end
        wait_drain();
        repeat (2 * FRAME) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
